// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/acknowledge bus between mem_access_unit (master)
//                and a variable-latency synchronous memory (slave).
//                  mem_req   - request valid, held until ack or abort
//                  mem_we    - write enable qualifying mem_req
//                  mem_addr  - request address
//                  mem_wdata - write data
//                  mem_ack   - completion; read data valid in same cycle
//                  mem_rdata - read data
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Turns the multicycle controller's single-cycle memory
//                strobes into a req/ack memory transaction, owns IR and MDR,
//                and stalls the controller until each access completes or
//                times out.
//  Ports       : clk, rst (async, active-low)
//                ir_write/mdr_write/mem_write/adr_src - controller strobes
//                pc, alu_addr, wdata                  - datapath inputs
//                mem (master modport)                 - memory bus
//                stall                                - freeze controller
//                ir, opcode, func, mdr                - captured registers
//                bus_err                              - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              ir_write,
    input  wire logic              mdr_write,
    input  wire logic              mem_write,
    input  wire logic              adr_src,
    input  wire logic [ADDR_W-1:0] pc,
    input  wire logic [ADDR_W-1:0] alu_addr,
    input  wire logic [DATA_W-1:0] wdata,
    mem_access_unit_if.master      mem,
    output logic                   stall,
    output logic [DATA_W-1:0]      ir,
    output logic [3:0]             opcode,
    output logic [8:0]             func,
    output logic [DATA_W-1:0]      mdr,
    output logic                   bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Destination of the access in flight, decided once when it is launched.
    typedef enum logic [1:0] {
        TGT_IR  = 2'd0,
        TGT_MDR = 2'd1,
        TGT_WR  = 2'd2
    } target_t;

    state_t            state_q,     state_d;
    target_t           target_q,    target_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ir_q,        ir_d;
    logic [DATA_W-1:0] mdr_q,       mdr_d;
    logic              bus_err_q,   bus_err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              stall_c;
    logic              any_strobe;

    assign any_strobe = ir_write | mdr_write | mem_write;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_c = any_strobe;
                if (any_strobe) begin
                    state_d     = ST_ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write;
                    mem_addr_d  = adr_src ? alu_addr : pc;
                    mem_wdata_d = wdata;
                    cnt_d       = '0;
                    // Store beats data read beats fetch; losers are dropped.
                    if (mem_write)      target_d = TGT_WR;
                    else if (mdr_write) target_d = TGT_MDR;
                    else                target_d = TGT_IR;
                end
            end

            ST_ACCESS: begin
                stall_c = 1'b1;
                if (mem.mem_ack) begin
                    // An ack in the final wait cycle still completes normally.
                    case (target_q)
                        TGT_IR:  ir_d  = mem.mem_rdata;
                        TGT_MDR: mdr_d = mem.mem_rdata;
                        default: ;
                    endcase
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == c_cnt_last) begin
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                // One unstalled cycle lets the controller advance; strobes
                // present now belong to the old step and are not restarted.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            target_q    <= TGT_IR;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Gated by rst so a strobe held during reset cannot stall the controller.
    assign stall         = rst & stall_c;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign ir      = ir_q;
    assign mdr     = mdr_q;
    assign opcode  = ir_q[15:12];
    assign func    = ir_q[8:0];
    assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. Acts as controller
//                and memory, and compares against a transaction-level model
//                of IR/MDR/bus_err contents and stall duration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              ir_write, mdr_write, mem_write, adr_src;
    logic [ADDR_W-1:0] pc, alu_addr;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic [DATA_W-1:0] ir, mdr;
    logic [3:0]        opcode;
    logic [8:0]        func;
    logic              bus_err;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ir_write  (ir_write),
        .mdr_write (mdr_write),
        .mem_write (mem_write),
        .adr_src   (adr_src),
        .pc        (pc),
        .alu_addr  (alu_addr),
        .wdata     (wdata),
        .mem       (mem_if),
        .stall     (stall),
        .ir        (ir),
        .opcode    (opcode),
        .func      (func),
        .mdr       (mdr),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: architectural register contents.
    logic [DATA_W-1:0] exp_ir, exp_mdr;
    logic              exp_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, "_ir"},     ir,      exp_ir);
        check_val({tag, "_mdr"},    mdr,     exp_mdr);
        check_val({tag, "_err"},    bus_err, exp_err);
        check_val({tag, "_opcode"}, opcode,  {28'd0, exp_ir[15:12]});
        check_val({tag, "_func"},   func,    {23'd0, exp_ir[8:0]});
    endtask

    // One controller step. strb = {mem_write, mdr_write, ir_write}.
    // waits < 0 means the memory never acks. Called and returns at
    // posedge+2, with the unit idle.
    task automatic do_access(input logic [2:0] strb, input logic src,
                             input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, input int waits,
                             input logic [DATA_W-1:0] rd, input bit late_ack);
        int                cycles;
        int                k;
        int                exp_cycles;
        logic              is_wr;
        logic [ADDR_W-1:0] exp_addr;
        is_wr    = strb[2];
        exp_addr = src ? a : p;
        {mem_write, mdr_write, ir_write} = strb;
        adr_src  = src;
        pc       = p;
        alu_addr = a;
        wdata    = wd;
        #1;
        cycles = 0;
        k      = 0;
        while (stall === 1'b1 && cycles < 64) begin
            cycles++;
            @(posedge clk); #1;
            mem_if.mem_ack = 1'b0;
            if (mem_if.mem_req === 1'b1) begin
                check_val("req_addr",  mem_if.mem_addr,  exp_addr);
                check_val("req_we",    mem_if.mem_we,    is_wr);
                check_val("req_wdata", mem_if.mem_wdata, wd);
                if (waits >= 0 && k == waits) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = rd;
                end else begin
                    mem_if.mem_rdata = DATA_W'($urandom);
                end
                k++;
                // Request fields must not follow the datapath once launched.
                pc       = ADDR_W'($urandom);
                alu_addr = ADDR_W'($urandom);
                wdata    = DATA_W'($urandom);
            end
        end
        // Model: outcome of the access by priority rule and ack/timeout.
        exp_cycles = (waits < 0) ? TIMEOUT + 1 : waits + 2;
        if (waits < 0)    exp_err = 1'b1;
        else if (strb[2]) ;
        else if (strb[1]) exp_mdr = rd;
        else              exp_ir  = rd;
        check_val("stall_cycles", cycles, exp_cycles);
        check_val("done_req", mem_if.mem_req, 1'b0);
        check_regs("done");
        // Strobes stay high through DONE; an ack here must be ignored.
        if (late_ack) begin
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = DATA_W'($urandom);
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        {mem_write, mdr_write, ir_write} = 3'b000;
        #1;
        check_val("idle_stall", stall, 1'b0);
        check_val("idle_req", mem_if.mem_req, 1'b0);
        check_regs("idle");
    endtask

    // Assert reset part-way through an access, then offer a stale ack.
    task automatic reset_mid(input logic [2:0] strb, input int hold);
        {mem_write, mdr_write, ir_write} = strb;
        adr_src  = 1'b0;
        pc       = ADDR_W'($urandom);
        wdata    = DATA_W'($urandom);
        #1;
        @(posedge clk); #1;
        check_val("rm_req", mem_if.mem_req, 1'b1);
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_ir  = '0;
        exp_mdr = '0;
        exp_err = 1'b0;
        check_val("rm_req0",   mem_if.mem_req,  1'b0);
        check_val("rm_stall0", stall,           1'b0);
        check_val("rm_addr0",  mem_if.mem_addr, 0);
        check_regs("rm");
        @(negedge clk);
        {mem_write, mdr_write, ir_write} = 3'b000;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = DATA_W'($urandom) | 16'h1;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        #1;
        check_val("rm_late_req",   mem_if.mem_req, 1'b0);
        check_val("rm_late_stall", stall,          1'b0);
        check_regs("rm_late");
    endtask

    initial begin
        logic [2:0] strb;
        int         waits;
        rst = 1'b0;
        {mem_write, mdr_write, ir_write} = 3'b001;
        adr_src  = 1'b0;
        pc       = '0;
        alu_addr = '0;
        wdata    = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        exp_ir  = '0;
        exp_mdr = '0;
        exp_err = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_stall", stall,            1'b0);
        check_val("rst_req",   mem_if.mem_req,   1'b0);
        check_val("rst_we",    mem_if.mem_we,    1'b0);
        check_val("rst_addr",  mem_if.mem_addr,  0);
        check_val("rst_wdata", mem_if.mem_wdata, 0);
        check_regs("rst");
        ir_write = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #2;

        // Fetch with single-cycle ack.
        do_access(3'b001, 1'b0, 12'h004, 12'h777, 16'h0000, 0, 16'h8123, 1'b0);
        // Data read with three wait cycles.
        do_access(3'b010, 1'b1, 12'h333, 12'h0A0, 16'h0000, 3, 16'hBEEF, 1'b1);
        // Store, two wait cycles.
        do_access(3'b100, 1'b1, 12'h555, 12'h010, 16'h1234, 2, 16'hDEAD, 1'b0);
        // Fetch and store together: store wins.
        do_access(3'b101, 1'b0, 12'h020, 12'h030, 16'h5A5A, 1, 16'hCAFE, 1'b1);
        // All three strobes: store wins.
        do_access(3'b111, 1'b1, 12'h021, 12'h031, 16'hA5A5, 0, 16'hF00D, 1'b0);
        // Data read and fetch together: data read wins.
        do_access(3'b011, 1'b0, 12'h040, 12'h050, 16'h0000, 0, 16'h4242, 1'b0);
        // Timeout, then a completed access: bus_err stays set.
        do_access(3'b010, 1'b1, 12'h000, 12'h0FF, 16'h0000, -1, 16'h9999, 1'b0);
        do_access(3'b001, 1'b0, 12'h100, 12'h000, 16'h0000, 0, 16'h7001, 1'b0);
        // Ack on the very last permitted cycle still completes.
        do_access(3'b001, 1'b0, 12'h101, 12'h000, 16'h0000, TIMEOUT - 1, 16'h6002, 1'b0);
        // Reset mid-access clears everything including bus_err.
        reset_mid(3'b001, 2);

        for (int i = 0; i < 30; i++) begin
            strb = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) begin
                reset_mid(strb, $urandom_range(0, TIMEOUT - 3));
            end else begin
                waits = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
                do_access(strb, 1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
                          DATA_W'($urandom), waits, DATA_W'($urandom), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle CPU controller/datapath and a variable-latency synchronous memory.
- Converts the controller's single-cycle memory strobes (IRWrite, MDRWrite, MemWrite with AdrSrc) into a req/ack memory transaction.
- Owns the instruction register (IR) and memory data register (MDR), and supplies opcode/func back to the controller.
- Raises stall until each access completes. The datapath gates PC/state/register writes with ~stall.

Parameters:
- DATA_W, 16: instruction/data word width. Opcode is IR[15:12], func is IR[8:0].
- ADDR_W, 12: memory address width.
- TIMEOUT, 15: maximum cycles to wait for mem_ack before aborting with bus_err.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- ir_write  input  1  controller requests an instruction fetch into IR
- mdr_write  input  1  controller requests a data read into MDR
- mem_write  input  1  controller requests a data write
- adr_src  input  1  address select: 0 = pc, 1 = alu_addr
- pc  input  ADDR_W  current PC
- alu_addr  input  ADDR_W  ALU-computed data address
- wdata  input  DATA_W  store data
- mem_req  output  1  memory request, registered
- mem_we  output  1  write enable qualifying mem_req, registered
- mem_addr  output  ADDR_W  registered request address
- mem_wdata  output  DATA_W  registered write data
- mem_ack  input  1  memory completion; for reads, rdata is valid in the same cycle
- mem_rdata  input  DATA_W  read data
- stall  output  1  combinational; freezes controller/datapath while 1
- ir  output  DATA_W  instruction register
- opcode  output  4  ir[15:12]
- func  output  9  ir[8:0]
- mdr  output  DATA_W  memory data register
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, ir, mdr, bus_err, and the wait counter all clear to 0.
  - stall is forced to 0 while rst=0.
  - A reset mid-access abandons the transaction with no write to IR/MDR.
- Strobe priority when more than one strobe is high: mem_write > mdr_write > ir_write. The losing strobes are ignored for that access.
- FSM state IDLE:
  - stall = any strobe.
  - On a clock edge with any strobe high, go to ACCESS and latch the request:
    - mem_addr = adr_src ? alu_addr : pc
    - mem_we = mem_write
    - mem_wdata = wdata
    - record the target (IR, MDR or write)
    - set mem_req=1
    - clear the counter
- FSM state ACCESS:
  - stall=1 and mem_req=1; request fields are held stable.
  - On mem_ack=1:
    - read to IR: ir <= mem_rdata.
    - read to MDR: mdr <= mem_rdata.
    - write: no register update.
    - mem_req <= 0, go to DONE.
  - Without ack, the counter increments each cycle. When the counter reaches TIMEOUT-1 with no ack:
    - bus_err <= 1 (held until reset).
    - mem_req <= 0.
    - IR/MDR are unchanged.
    - go to DONE.
- FSM state DONE:
  - stall=0 for exactly one cycle so the controller advances; go to IDLE.
  - Strobes seen in DONE are not restarted. The controller has moved on by the next edge, and the new state's strobes are sampled in IDLE.
- Latency: the strobe is asserted at cycle t. With ack in the first ACCESS cycle (t+1), stall is 0 at t+2. Each extra wait cycle adds 1.
- Writes count as complete only on mem_ack. Write and read use identical timing.
- mem_ack while in IDLE or DONE is ignored.
- opcode/func are combinational slices of ir and update the cycle after the capture edge.
- No width arithmetic besides the counter, which is $clog2(TIMEOUT+1) bits and saturates (no wrap).
- A write (mem_write) must not alter mdr; a fetch must not alter mdr; a data read must not alter ir.

Test Plan:
- Reset then fetch: rst 0→1, pc=0x004, ir_write=1, memory acks 1 cycle after req with 0x8123. Required: stall=1 for 2 cycles; mem_addr=0x004, mem_we=0; ir=0x8123, opcode=4'h8, func=9'h123; stall=0 in DONE.
- Wait states: data read, adr_src=1, alu_addr=0x0A0, ack after 3 wait cycles with 0xBEEF. Required: mdr=0xBEEF, ir unchanged, stall high 5 cycles total.
- Store: mem_write=1, alu_addr=0x010, wdata=0x1234. Required: mem_req=1, mem_we=1, mem_addr=0x010, mem_wdata=0x1234 held until ack; ir and mdr unchanged.
- Simultaneous strobes: ir_write=1 and mem_write=1 together. Required: a write transaction (mem_we=1) and ir not updated.
- Timeout: read with mem_ack never asserted and TIMEOUT=15. Required: bus_err=1 after 15 ACCESS cycles, mem_req drops, stall releases for 1 cycle, bus_err stays 1 until rst=0.
- Reset mid-access: rst=0 during ACCESS before ack. Required: mem_req=0, stall=0, ir=0 immediately; after release, state is IDLE and a late ack has no effect.
